mips_mc_control: RTL

Multi-cycle control sequencer for the MIPS datapath. It drives the enables and mux selects of the datapath registers (PC, IR, MDR, A/B, ALUOut, register file) from the IR opcode, one instruction step per state. It waits on a variable-latency memory through a ready handshake. It sits between the instruction register and every register-enable and mux-select input of the datapath.

---
 rtl/mips_mc_control.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control sequencer: one datapath step per state, memory waits via mem_ready.
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP and raise illegal_op.
module mips_mc_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state
);

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9;
  localparam logic [3:0] ST_ADDIEX = 4'd10;
  localparam logic [3:0] ST_ADDIWB = 4'd11;
  localparam logic [3:0] ST_TRAP   = 4'd15;

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       known_op_s;

  logic       pc_write_s, pc_write_cond_s, i_or_d_s, mem_read_s, mem_write_s;
  logic       ir_write_s, mem_to_reg_s, reg_dst_s, reg_write_s, alu_src_a_s;
  logic       instr_done_s, illegal_s;
  logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  assign known_op_s = is_known_op(opcode);

  // State register; reset returns the sequencer to FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode from state, opcode and the memory handshake.
  always_comb begin
    next_state_s = ST_FETCH;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) next_state_s = ST_DECODE;
        else           next_state_s = ST_FETCH;
      end
      ST_DECODE: begin
        if      ((opcode == OP_LW) || (opcode == OP_SW)) next_state_s = ST_MEMADR;
        else if (opcode == OP_RTYPE)                     next_state_s = ST_EXEC;
        else if (opcode == OP_BEQ)                       next_state_s = ST_BRANCH;
        else if (opcode == OP_J)                         next_state_s = ST_JUMP;
        else if (opcode == OP_ADDI)                      next_state_s = ST_ADDIEX;
`ifdef MC_ILLEGAL_TRAP_EN
        else                                             next_state_s = ST_TRAP;
`else
        else                                             next_state_s = ST_FETCH;
`endif
      end
      ST_MEMADR: begin
        if      (opcode == OP_LW) next_state_s = ST_MEMRD;
        else if (opcode == OP_SW) next_state_s = ST_MEMWR;
        else                      next_state_s = ST_FETCH;
      end
      ST_MEMRD: begin
        if (mem_ready) next_state_s = ST_MEMWB;
        else           next_state_s = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready) next_state_s = ST_FETCH;
        else           next_state_s = ST_MEMWR;
      end
      ST_EXEC:   next_state_s = ST_ALUWB;
      ST_ADDIEX: next_state_s = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: next_state_s = ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP:   next_state_s = ST_TRAP;
`else
      ST_TRAP:   next_state_s = ST_FETCH;
`endif
      default:   next_state_s = ST_FETCH;
    endcase
  end

  // Per-state output decode, qualified by mem_ready in the memory states.
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'd0;
    alu_op_s        = 2'd0;
    pc_source_s     = 2'd0;
    instr_done_s    = 1'b0;
    illegal_s       = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'd1;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b_s = 2'd3;
`ifdef MC_ILLEGAL_TRAP_EN
        instr_done_s = 1'b0;
`else
        instr_done_s = !known_op_s;
`endif
      end
      ST_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
      end
      ST_MEMRD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
      end
      ST_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_MEMWR: begin
        mem_write_s  = 1'b1;
        i_or_d_s     = 1'b1;
        instr_done_s = mem_ready;
      end
      ST_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'd2;
      end
      ST_ALUWB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'd1;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'd1;
        instr_done_s    = 1'b1;
      end
      ST_JUMP: begin
        pc_write_s   = 1'b1;
        pc_source_s  = 2'd2;
        instr_done_s = 1'b1;
      end
      ST_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
      end
      ST_ADDIWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_s = 1'b1;
`else
        illegal_s = 1'b0;
`endif
      end
      default: begin
        illegal_s = 1'b0;
      end
    endcase
  end

  // Writes and requests are forced off for as long as reset is held low.
  assign pc_write      = reset & pc_write_s;
  assign pc_write_cond = reset & pc_write_cond_s;
  assign mem_read      = reset & mem_read_s;
  assign mem_write     = reset & mem_write_s;
  assign ir_write      = reset & ir_write_s;
  assign reg_write     = reset & reg_write_s;
  assign instr_done    = reset & instr_done_s;
  assign i_or_d        = i_or_d_s;
  assign mem_to_reg    = mem_to_reg_s;
  assign reg_dst       = reg_dst_s;
  assign alu_src_a     = alu_src_a_s;
  assign alu_src_b     = alu_src_b_s;
  assign alu_op        = alu_op_s;
  assign pc_source     = pc_source_s;
  assign state         = state_r;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_op    = reset & illegal_s;
`else
  logic unused_s;
  assign unused_s = illegal_s;
`endif

endmodule
